// File: rtl/input_pkg.sv
// Shared definitions for the push-button input path.
// Holds the key bit positions, the debounce constants and the
// per-channel event bundle used by key_debounce_ch.
package input_pkg;

  // Bit positions inside the key vector
  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_UP    = 2;
  localparam int KEY_DOWN  = 3;

  // 1 ms at a 50 MHz board clock
  localparam int DEBOUNCE_1MS_50MHZ = 50000;
  // Short window used in simulation
  localparam int DEBOUNCE_SIM = 4;

  // Registered per-channel state: debounced level plus edge pulses
  typedef struct packed {
    logic db;
    logic pressed;
    logic released;
  } key_evt_t;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, counter-based debouncer and
// single-cycle press/release pulse generator.
// Ports:
//   clk      - board clock, rising edge
//   reset    - asynchronous active-low reset
//   k_in     - polarity-corrected asynchronous key level (1 = pressed)
//   db       - debounced level (registered)
//   pressed  - one-cycle pulse on a debounced 0->1 transition (registered)
//   released - one-cycle pulse on a debounced 1->0 transition (registered)
module key_debounce_ch
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_50MHZ,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic k_in,
  output logic db,
  output logic pressed,
  output logic released
);

  // Last count value; reaching it with a still-differing input accepts
  // the new level, so the counter never needs to wrap.
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  key_evt_t         evt;
  key_evt_t         evt_next;

  // Two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= k_in;
      s2 <= s1;
    end
  end

  // Debounce decision: any agreement with the current level clears the
  // count, so a bounce train restarts the window with no partial credit.
  always_comb begin
    cnt_next          = cnt;
    evt_next          = evt;
    evt_next.pressed  = 1'b0;
    evt_next.released = 1'b0;
    if (s2 == evt.db) begin
      cnt_next = '0;
    end else if (cnt == TERM) begin
      cnt_next          = '0;
      evt_next.db       = s2;
      evt_next.pressed  = s2;
      evt_next.released = ~s2;
    end else begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  // Counter and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      evt <= '0;
    end else begin
      cnt <= cnt_next;
      evt <= evt_next;
    end
  end

  assign db       = evt.db;
  assign pressed  = evt.pressed;
  assign released = evt.released;

endmodule

// File: rtl/key_input_conditioner.sv
// Conditions raw board push-buttons into a clean key vector.
// Applies the pin polarity, then runs one independent debounce channel
// per key; any_key is the combinational OR of the debounced levels.
// Ports:
//   clk          - board clock, rising edge
//   reset        - asynchronous active-low reset
//   keys_raw     - raw asynchronous button pins
//   keys_db      - debounced levels, 1 = pressed
//   key_pressed  - one-cycle pulse per key on debounced 0->1
//   key_released - one-cycle pulse per key on debounced 1->0
//   any_key      - OR of keys_db
module key_input_conditioner
  import input_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_50MHZ,
  parameter int CNT_W           = 16,
  parameter int ACTIVE_LOW_KEYS = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys_raw,
  output logic [NUM_KEYS-1:0] keys_db,
  output logic [NUM_KEYS-1:0] key_pressed,
  output logic [NUM_KEYS-1:0] key_released,
  output logic                any_key
);

  localparam logic INVERT = 1'(ACTIVE_LOW_KEYS);

  logic [NUM_KEYS-1:0] k_in;

  // Normalise so that 1 always means pressed before synchronisation
  assign k_in = keys_raw ^ {NUM_KEYS{INVERT}};

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .k_in    (k_in[i]),
      .db      (keys_db[i]),
      .pressed (key_pressed[i]),
      .released(key_released[i])
    );
  end

  assign any_key = |keys_db;

endmodule

// File: tb/tb_key_input_conditioner.sv
module tb_key_input_conditioner;
  import input_pkg::*;

  localparam int D = DEBOUNCE_SIM;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] raw0  = 4'h0;
  logic [3:0] raw1  = 4'hF;

  logic [3:0] db0, pr0, rl0;
  logic       any0;
  logic [3:0] db1, pr1, rl1;
  logic       any1;

  always #5 clk = ~clk;

  key_input_conditioner #(
    .NUM_KEYS(4), .DEBOUNCE_CYCLES(D), .CNT_W(16), .ACTIVE_LOW_KEYS(0)
  ) dut (
    .clk(clk), .reset(reset), .keys_raw(raw0), .keys_db(db0),
    .key_pressed(pr0), .key_released(rl0), .any_key(any0)
  );

  key_input_conditioner #(
    .NUM_KEYS(4), .DEBOUNCE_CYCLES(D), .CNT_W(16), .ACTIVE_LOW_KEYS(1)
  ) dut_al (
    .clk(clk), .reset(reset), .keys_raw(raw1), .keys_db(db1),
    .key_pressed(pr1), .key_released(rl1), .any_key(any1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: the pressed/released level seen by the debouncer is
  // the pin level from two edges earlier; a key's accepted level flips once
  // that delayed level has disagreed with it on D consecutive edges.
  logic [3:0] m_d1[2];
  logic [3:0] m_d2[2];
  logic [3:0] m_db[2];
  logic [3:0] m_pr[2];
  logic [3:0] m_rl[2];
  int         m_run[2][4];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_d1[k] = 4'h0; m_d2[k] = 4'h0; m_db[k] = 4'h0;
      m_pr[k] = 4'h0; m_rl[k] = 4'h0;
      for (int i = 0; i < 4; i++) m_run[k][i] = 0;
    end
  endtask

  task automatic model_edge();
    logic [3:0] lvl;
    for (int k = 0; k < 2; k++) begin
      lvl = (k == 0) ? raw0 : ~raw1;
      if (!reset) begin
        model_reset();
      end else begin
        m_pr[k] = 4'h0;
        m_rl[k] = 4'h0;
        for (int i = 0; i < 4; i++) begin
          if (m_d2[k][i] != m_db[k][i]) begin
            m_run[k][i] = m_run[k][i] + 1;
            if (m_run[k][i] == D) begin
              m_db[k][i]  = m_d2[k][i];
              m_run[k][i] = 0;
              if (m_db[k][i]) m_pr[k][i] = 1'b1;
              else            m_rl[k][i] = 1'b1;
            end
          end else begin
            m_run[k][i] = 0;
          end
        end
        m_d2[k] = m_d1[k];
        m_d1[k] = lvl;
      end
    end
  endtask

  // One clock edge, model update, then compare both DUTs against the model
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_hi", {19'b0, db0, pr0, rl0, any0}, {19'b0, m_db[0], m_pr[0], m_rl[0], |m_db[0]});
    check("model_lo", {19'b0, db1, pr1, rl1, any1}, {19'b0, m_db[1], m_pr[1], m_rl[1], |m_db[1]});
  endtask

  task automatic settle();
    raw0 = 4'h0;
    raw1 = 4'hF;
    repeat (8) tick();
  endtask

  typedef struct {
    logic [3:0] raw;
    logic [3:0] db;
    logic [3:0] pr;
    logic [3:0] rl;
    logic       any;
  } vec_t;

  function automatic vec_t mk(logic [3:0] r, logic [3:0] d, logic [3:0] p, logic [3:0] l, logic a);
    vec_t v;
    v.raw = r; v.db = d; v.pr = p; v.rl = l; v.any = a;
    return v;
  endfunction

  initial begin
    vec_t tbl[14];
    int   pulses;
    logic seen;

    // Clean press of key 0 followed by its release, one record per edge
    tbl[0]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tbl[1]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tbl[2]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tbl[3]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tbl[4]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tbl[5]  = mk(4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1);
    tbl[6]  = mk(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    tbl[7]  = mk(4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    tbl[8]  = mk(4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    tbl[9]  = mk(4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    tbl[10] = mk(4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    tbl[11] = mk(4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    tbl[12] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    tbl[13] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    model_reset();

    // Reset held with all keys pressed
    raw0 = 4'hF;
    repeat (3) tick();
    check("in_reset", {19'b0, db0, pr0, rl0, any0}, 32'h0);
    reset = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 1) check("after_release", {19'b0, db0, pr0, rl0, any0}, 32'h0);
      if (e < 6)  check("rst_db_wait", {28'b0, db0}, 32'h0);
      if (e == 6) check("rst_db_pr", {24'b0, db0, pr0}, {24'b0, 4'hF, 4'hF});
      if (e == 7) check("rst_pr_once", {24'b0, db0, pr0}, {24'b0, 4'hF, 4'h0});
    end
    settle();

    // Table-driven clean press and release
    for (int i = 0; i < 14; i++) begin
      raw0 = tbl[i].raw;
      tick();
      check($sformatf("vec%0d", i), {19'b0, db0, pr0, rl0, any0},
            {19'b0, tbl[i].db, tbl[i].pr, tbl[i].rl, tbl[i].any});
    end
    settle();

    // Bounce train on key 2: final rise is before edge 9, accepted at edge 14
    pulses = 0;
    for (int e = 1; e <= 16; e++) begin
      raw0[2] = (e <= 2) || (e >= 5 && e <= 6) || (e >= 9);
      tick();
      check($sformatf("bounce_e%0d", e), {31'b0, db0[2]}, {31'b0, (e >= 14)});
      pulses += int'(pr0[2]);
    end
    check("bounce_pulses", 32'(pulses), 32'd1);
    settle();

    // Short glitch on key 1: three cycles high is one short of acceptance
    seen = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      raw0[1] = (e <= 3);
      tick();
      seen = seen | db0[1] | pr0[1] | rl0[1];
    end
    check("glitch_quiet", {31'b0, seen}, 32'h0);
    settle();

    // Simultaneous release and press on different keys
    raw0 = 4'b1010;
    repeat (8) tick();
    check("multi_pre", {28'b0, db0}, {28'b0, 4'b1010});
    raw0 = 4'b0101;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) check("multi_e5", {20'b0, db0, pr0, rl0}, {20'b0, 4'b1010, 4'b0000, 4'b0000});
      if (e == 6) check("multi_e6", {20'b0, db0, pr0, rl0}, {20'b0, 4'b0101, 4'b0101, 4'b1010});
      if (e == 7) check("multi_e7", {20'b0, db0, pr0, rl0}, {20'b0, 4'b0101, 4'b0000, 4'b0000});
    end
    settle();

    // Reset asserted while key 0 is mid-count and key 3 is debounced high
    raw0 = 4'b1000;
    repeat (8) tick();
    check("midrst_pre", {28'b0, db0}, {28'b0, 4'b1000});
    raw0 = 4'b1001;
    repeat (4) tick();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("midrst_async", {19'b0, db0, pr0, rl0, any0}, 32'h0);
    raw0 = 4'h0;
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      seen = seen | (|pr0) | (|rl0) | (|db0);
    end
    check("midrst_quiet", {31'b0, seen}, 32'h0);

    // Active-low pins: all high means released, bit 0 low means left pressed
    raw1 = 4'hF;
    repeat (8) tick();
    check("pol_idle", {24'b0, db1, pr1}, 32'h0);
    raw1 = 4'hE;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) check("pol_e5", {28'b0, db1}, 32'h0);
      if (e == 6) check("pol_e6", {23'b0, db1, pr1, any1}, {23'b0, 4'b0001, 4'b0001, 1'b1});
      if (e == 7) check("pol_e7", {24'b0, db1, pr1}, {24'b0, 4'b0001, 4'b0000});
    end
    settle();

    // Random pin activity on both instances, with occasional async resets
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 5) == 0) raw0[i] = ~raw0[i];
        if ($urandom_range(0, 5) == 0) raw1[i] = ~raw1[i];
      end
      if ($urandom_range(0, 199) == 0) begin
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("rand_rst", {6'b0, db0, pr0, rl0, db1, pr1, rl1, any0, any1}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
